// File: rtl/alu_div_sequencer_if.sv
// Handshake and shared-ALU signals between the execute stage and the
// division sequencer. The master side is the pipeline/ALU, the slave side
// is the sequencer.
interface alu_div_sequencer_if #(
    parameter int unsigned XLEN = 32
);
    logic            start;
    logic [1:0]      op;
    logic [XLEN-1:0] dividend;
    logic [XLEN-1:0] divisor;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic            alu_req;
    logic            alu_gnt;
    logic [XLEN-1:0] alu_a;
    logic [XLEN-1:0] alu_b;
    logic [3:0]      alu_op;
    logic [XLEN-1:0] alu_result;
    logic            alu_carry;

    modport master (
        output start, op, dividend, divisor, alu_gnt, alu_result, alu_carry,
        input  busy, done, result, alu_req, alu_a, alu_b, alu_op
    );

    modport slave (
        input  start, op, dividend, divisor, alu_gnt, alu_result, alu_carry,
        output busy, done, result, alu_req, alu_a, alu_b, alu_op
    );
endinterface

// File: rtl/alu_div_sequencer.sv
// Multi-cycle DIV/DIVU/REM/REMU sequencer. Performs one restoring-division
// step per granted cycle on the shared ALU (SUB), with magnitude conversion
// before the loop and sign correction after it.
module alu_div_sequencer #(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned ITERS = 32
) (
    input logic               clk,
    input logic               rst,
    alu_div_sequencer_if.slave bus
);
    localparam logic [3:0]      ALU_SUB = 4'd1;
    localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [5:0]      LAST    = 6'(ITERS - 1);

    typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;

    state_t          state, state_nxt;
    logic [1:0]      op_q;
    logic [XLEN-1:0] dvd_q, dvs_q, quo, rem, result_q;
    logic [5:0]      count;
    logic            neg_q, neg_r;
    logic            div0, ovf, signed_op;
    logic [XLEN-1:0] step_a;
    logic            step_ok;

    // Special-case detection on the live request operands (only used in IDLE).
    always_comb begin
        div0      = (bus.divisor == '0);
        ovf       = !bus.op[0] && (bus.dividend == MIN_NEG) && (bus.divisor == '1);
        signed_op = !op_q[0];
        // Shifted partial remainder; rem[XLEN-1] stands in for the carry lost
        // when the shift pushes a bit out past the ALU width.
        step_a    = {rem[XLEN-2:0], quo[XLEN-1]};
        step_ok   = bus.alu_carry | rem[XLEN-1];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start) state_nxt = (div0 || ovf) ? DONE : PREP;
            PREP:    state_nxt = ITER;
            ITER:    if (bus.alu_gnt && count == LAST) state_nxt = FIX;
            FIX:     state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: operand capture, magnitude prep, division steps, sign fix.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= '0;
            dvd_q    <= '0;
            dvs_q    <= '0;
            quo      <= '0;
            rem      <= '0;
            count    <= '0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            result_q <= '0;
        end else begin
            case (state)
                IDLE: if (bus.start) begin
                    op_q  <= bus.op;
                    dvd_q <= bus.dividend;
                    dvs_q <= bus.divisor;
                    if (div0)
                        result_q <= bus.op[1] ? bus.dividend : '1;
                    else if (ovf)
                        result_q <= bus.op[1] ? '0 : MIN_NEG;
                end
                PREP: begin
                    neg_q <= signed_op & (dvd_q[XLEN-1] ^ dvs_q[XLEN-1]);
                    neg_r <= signed_op & dvd_q[XLEN-1];
                    quo   <= (signed_op && dvd_q[XLEN-1]) ? -dvd_q : dvd_q;
                    dvs_q <= (signed_op && dvs_q[XLEN-1]) ? -dvs_q : dvs_q;
                    rem   <= '0;
                    count <= '0;
                end
                ITER: if (bus.alu_gnt) begin
                    rem   <= step_ok ? bus.alu_result : step_a;
                    quo   <= {quo[XLEN-2:0], step_ok};
                    count <= count + 6'd1;
                end
                FIX: begin
                    if (op_q[1]) result_q <= neg_r ? -rem : rem;
                    else         result_q <= neg_q ? -quo : quo;
                end
                default: ;
            endcase
        end
    end

    // Outputs decoded from state; ALU operands are zero outside ITER.
    always_comb begin
        bus.busy    = (state != IDLE);
        bus.done    = (state == DONE);
        bus.alu_req = (state == ITER);
        bus.alu_a   = (state == ITER) ? step_a : '0;
        bus.alu_b   = (state == ITER) ? dvs_q  : '0;
        bus.alu_op  = ALU_SUB;
        bus.result  = result_q;
    end
endmodule

// File: tb/tb_alu_div_sequencer.sv
// Directed testbench for alu_div_sequencer with a behavioural SUB ALU.
module tb_alu_div_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    alu_div_sequencer_if #(.XLEN(32)) bus ();

    alu_div_sequencer #(.XLEN(32), .ITERS(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Shared ALU model: SUB with carry = no-borrow.
    assign bus.alu_result = bus.alu_a - bus.alu_b;
    assign bus.alu_carry  = (bus.alu_a >= bus.alu_b);

    // Issues one operation and observes it to completion plus one cycle.
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int stall_at, input int stall_len, input bit pulse_start,
                          output logic [31:0] res, output int done_cyc, output bit req_seen,
                          output bit busy_ok, output bit ab_stable, output bit post_idle,
                          output logic [31:0] post_res);
        int cyc, grants, stalled;
        bit prev_stall;
        logic [31:0] pa, pb;
        res = '0; done_cyc = -1; req_seen = 0; busy_ok = 1; ab_stable = 1;
        grants = 0; stalled = 0; prev_stall = 0; pa = '0; pb = '0;
        bus.op = op; bus.dividend = a; bus.divisor = b; bus.start = 1'b1; bus.alu_gnt = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.dividend = 32'hDEADBEEF; bus.divisor = 32'h3; bus.op = ~op;
        cyc = 1;
        while (cyc <= 200) begin
            if (stall_at >= 0 && bus.alu_req && grants == stall_at && stalled < stall_len) begin
                bus.alu_gnt = 1'b0;
                stalled++;
            end else begin
                bus.alu_gnt = 1'b1;
            end
            if (prev_stall && (bus.alu_a !== pa || bus.alu_b !== pb)) ab_stable = 0;
            prev_stall = !bus.alu_gnt;
            pa = bus.alu_a;
            pb = bus.alu_b;
            if (bus.alu_req === 1'b1) req_seen = 1;
            if (bus.alu_req && bus.alu_gnt) grants++;
            if (bus.busy !== 1'b1) busy_ok = 0;
            if (pulse_start && cyc == 10) begin
                bus.start = 1'b1; bus.dividend = 32'd1; bus.divisor = 32'd1; bus.op = 2'b01;
            end else begin
                bus.start = 1'b0;
            end
            if (bus.done === 1'b1) begin
                res = bus.result;
                done_cyc = cyc;
                if (pulse_start) bus.start = 1'b1;
                break;
            end
            @(posedge clk); #1;
            cyc++;
        end
        @(posedge clk); #1;
        bus.start = 1'b0; bus.alu_gnt = 1'b1;
        post_idle = (bus.busy === 1'b0 && bus.done === 1'b0);
        post_res  = bus.result;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got %b exp 0", bus.busy); end
        checks++; if (bus.done !== 1'b0)     begin errors++; $display("FAIL reset_done got %b exp 0", bus.done); end
        checks++; if (bus.result !== 32'h0)  begin errors++; $display("FAIL reset_result got %h exp 0", bus.result); end
        checks++; if (bus.alu_req !== 1'b0)  begin errors++; $display("FAIL reset_req got %b exp 0", bus.alu_req); end
        checks++; if (bus.alu_a !== 32'h0)   begin errors++; $display("FAIL reset_alu_a got %h exp 0", bus.alu_a); end
        checks++; if (bus.alu_b !== 32'h0)   begin errors++; $display("FAIL reset_alu_b got %h exp 0", bus.alu_b); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_unsigned;
        logic [31:0] res, pres;
        int dc;
        bit rq, bok, abs_ok, pidle;
        run_op(2'b01, 32'd100, 32'd7, -1, 0, 0, res, dc, rq, bok, abs_ok, pidle, pres);
        checks++; if (res !== 32'd14) begin errors++; $display("FAIL divu_res got %h exp %h", res, 32'd14); end
        checks++; if (dc != 35)       begin errors++; $display("FAIL divu_cycle got %0d exp 35", dc); end
        checks++; if (!bok)           begin errors++; $display("FAIL divu_busy got low exp high cycles 1-35"); end
        checks++; if (!pidle)         begin errors++; $display("FAIL divu_idle got busy/done exp idle after done"); end
        checks++; if (pres !== 32'd14) begin errors++; $display("FAIL divu_hold got %h exp %h", pres, 32'd14); end
        run_op(2'b11, 32'd100, 32'd7, -1, 0, 0, res, dc, rq, bok, abs_ok, pidle, pres);
        checks++; if (res !== 32'd2)  begin errors++; $display("FAIL remu_res got %h exp %h", res, 32'd2); end
        checks++; if (dc != 35)       begin errors++; $display("FAIL remu_cycle got %0d exp 35", dc); end
    endtask

    task automatic test_signed;
        logic [1:0]  ops [6] = '{2'b00, 2'b10, 2'b00, 2'b10, 2'b01, 2'b11};
        logic [31:0] as  [6] = '{32'hFFFFFFF9, 32'hFFFFFFF9, 32'd7, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] bs  [6] = '{32'd2, 32'd2, 32'hFFFFFFFE, 32'hFFFFFFFE, 32'h80000001, 32'h80000001};
        logic [31:0] exs [6] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'd1, 32'd1, 32'h7FFFFFFE};
        logic [31:0] res, pres;
        int dc;
        bit rq, bok, abs_ok, pidle;
        for (int unsigned i = 0; i < 6; i++) begin
            run_op(ops[i], as[i], bs[i], -1, 0, 0, res, dc, rq, bok, abs_ok, pidle, pres);
            checks++; if (res !== exs[i]) begin errors++; $display("FAIL signed_res[%0d] got %h exp %h", i, res, exs[i]); end
            checks++; if (dc != 35)       begin errors++; $display("FAIL signed_cycle[%0d] got %0d exp 35", i, dc); end
        end
    endtask

    task automatic test_special;
        logic [1:0]  ops [4] = '{2'b01, 2'b10, 2'b00, 2'b10};
        logic [31:0] as  [4] = '{32'd5, 32'd5, 32'h80000000, 32'h80000000};
        logic [31:0] bs  [4] = '{32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF};
        logic [31:0] exs [4] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0};
        logic [31:0] res, pres;
        int dc;
        bit rq, bok, abs_ok, pidle;
        for (int unsigned i = 0; i < 4; i++) begin
            run_op(ops[i], as[i], bs[i], -1, 0, 0, res, dc, rq, bok, abs_ok, pidle, pres);
            checks++; if (res !== exs[i]) begin errors++; $display("FAIL special_res[%0d] got %h exp %h", i, res, exs[i]); end
            checks++; if (dc != 1)        begin errors++; $display("FAIL special_cycle[%0d] got %0d exp 1", i, dc); end
            checks++; if (rq)             begin errors++; $display("FAIL special_req[%0d] got 1 exp 0", i); end
            checks++; if (!pidle)         begin errors++; $display("FAIL special_idle[%0d] got busy exp idle", i); end
        end
    endtask

    task automatic test_stall;
        logic [31:0] res, pres;
        int dc;
        bit rq, bok, abs_ok, pidle;
        run_op(2'b01, 32'd100, 32'd7, 10, 5, 1, res, dc, rq, bok, abs_ok, pidle, pres);
        checks++; if (res !== 32'd14)  begin errors++; $display("FAIL stall_res got %h exp %h", res, 32'd14); end
        checks++; if (dc != 40)        begin errors++; $display("FAIL stall_cycle got %0d exp 40", dc); end
        checks++; if (!abs_ok)         begin errors++; $display("FAIL stall_ab got changing exp stable"); end
        checks++; if (!bok)            begin errors++; $display("FAIL stall_busy got low exp high"); end
        checks++; if (!pidle)          begin errors++; $display("FAIL stall_done_start got busy exp idle"); end
        checks++; if (pres !== 32'd14) begin errors++; $display("FAIL stall_hold got %h exp %h", pres, 32'd14); end
    endtask

    task automatic test_reset_mid_op;
        logic [31:0] res, pres;
        int dc, grants;
        bit rq, bok, abs_ok, pidle;
        bus.op = 2'b01; bus.dividend = 32'd100; bus.divisor = 32'd7; bus.start = 1'b1; bus.alu_gnt = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        grants = 0;
        for (int unsigned i = 0; i < 100 && grants < 10; i++) begin
            if (bus.alu_req && bus.alu_gnt) grants++;
            @(posedge clk); #1;
        end
        checks++; if (grants != 10) begin errors++; $display("FAIL rstmid_reach got %0d exp 10", grants); end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++; if (bus.busy !== 1'b0)    begin errors++; $display("FAIL rstmid_busy got %b exp 0", bus.busy); end
        checks++; if (bus.done !== 1'b0)    begin errors++; $display("FAIL rstmid_done got %b exp 0", bus.done); end
        checks++; if (bus.result !== 32'h0) begin errors++; $display("FAIL rstmid_result got %h exp 0", bus.result); end
        checks++; if (bus.alu_req !== 1'b0) begin errors++; $display("FAIL rstmid_req got %b exp 0", bus.alu_req); end
        @(posedge clk); #1;
        checks++; if (bus.done !== 1'b0)    begin errors++; $display("FAIL rstmid_nodone got %b exp 0", bus.done); end
        run_op(2'b01, 32'd9, 32'd3, -1, 0, 0, res, dc, rq, bok, abs_ok, pidle, pres);
        checks++; if (res !== 32'd3) begin errors++; $display("FAIL rstmid_fresh_res got %h exp %h", res, 32'd3); end
        checks++; if (dc != 35)      begin errors++; $display("FAIL rstmid_fresh_cycle got %0d exp 35", dc); end
    endtask

    initial begin
        bus.start = 1'b0; bus.op = 2'b00; bus.dividend = '0; bus.divisor = '0; bus.alu_gnt = 1'b1;
        test_reset();
        test_unsigned();
        test_signed();
        test_special();
        test_stall();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_div_sequencer.md
Name: alu_div_sequencer

Overview:
Multi-cycle sequencer for RISC-V M-extension DIV/DIVU/REM/REMU. It borrows the shared 32-bit ALU for one restoring-division step per cycle, issuing SUB and using the ALU result and carry-out. ALU ownership is arbitrated by a req/gnt pair. Signed operands are handled by magnitude conversion before iteration and sign correction after it. Sits beside the execute stage; the pipeline stalls on busy.

Parameters:
XLEN, 32, operand/result width (only 32 supported)
ITERS, 32, division steps (must equal XLEN)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  request; sampled only in IDLE
op  in  2  funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
dividend  in  32  rs1 value
divisor  in  32  rs2 value
busy  out  1  high from cycle after accepted start until done cycle inclusive
done  out  1  one-cycle pulse, result valid
result  out  32  quotient or remainder; held until next accepted start
alu_req  out  1  high while in ITER
alu_gnt  in  1  ALU granted this cycle
alu_a  out  32  ALU SrcA
alu_b  out  32  ALU SrcB
alu_op  out  4  ALU op; constant `SUB from the shared defines
alu_result  in  32  ALU result
alu_carry  in  1  ALU carry-out; 1 means A>=B unsigned on SUB

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- Reset values: state IDLE, busy 0, done 0, result 0, alu_req 0, alu_a 0, alu_b 0.
- rst mid-operation aborts the operation immediately. The following cycle is IDLE with no done.
- States: IDLE, PREP, ITER, FIX, DONE.
- IDLE + start:
  - Latch op, dividend and divisor.
  - Divide by zero: result = 0xFFFFFFFF for DIV/DIVU, or dividend for REM/REMU. Go to DONE.
  - Signed overflow (DIV/REM, dividend 0x80000000, divisor 0xFFFFFFFF): result = 0x80000000 for DIV, 0 for REM. Go to DONE.
  - Otherwise go to PREP.
- PREP (1 cycle):
  - Signed ops: take |dividend| and |divisor|. Record neg_q = sign(dividend) XOR sign(divisor) and neg_r = sign(dividend).
  - Unsigned ops: use operands as-is, neg_q = neg_r = 0.
  - quo = |dividend|, rem = 0, count = 0. Go to ITER.
- ITER (one step per cycle in which alu_gnt = 1):
  - alu_a = {rem[30:0], quo[31]}, alu_b = |divisor|.
  - Step succeeds if alu_carry OR rem[31]. rem[31] = 1 covers the lost bit 32 when unsigned divisor >= 2^31.
  - Success: rem <= alu_result, quo <= {quo[30:0], 1}.
  - Failure: rem <= alu_a, quo <= {quo[30:0], 0}.
  - count++. After the 32nd granted step go to FIX.
  - alu_gnt = 0: no state change. alu_req stays high; alu_a and alu_b stay stable.
- FIX (1 cycle): result = neg_q ? -quo : quo for DIV/DIVU; result = neg_r ? -rem : rem for REM/REMU. Go to DONE.
- DONE (1 cycle): done = 1, busy = 1. Go to IDLE.
- start while not IDLE is ignored, including in the DONE cycle.
- Latency with alu_gnt tied 1, counting start-sampled edge as cycle 0:
  - Normal op: done in cycle 35.
  - Special case: done in cycle 1.
  - Each denied-grant cycle adds 1.
- Negation is two's complement in 32 bits, internal to the block; it does not use the ALU.
- Operand inputs may change after the start cycle without effect.

Test Plan:
- DIVU 100/7, gnt=1 -> done in cycle 35, result 14; REMU same operands -> 2; busy high cycles 1–35.
- DIV 0xFFFFFFF9(-7)/2 -> 0xFFFFFFFD; REM -> 0xFFFFFFFF; DIV 7/0xFFFFFFFE(-2) -> 0xFFFFFFFD; REM 7/-2 -> 1.
- DIVU 0xFFFFFFFF/0x80000001 -> 1 and REMU -> 0x7FFFFFFE (exercises rem[31] path).
- Special cases:
  - DIVU 5/0 -> 0xFFFFFFFF, done in cycle 1, alu_req never asserted.
  - REM 5/0 -> 5.
  - DIV 0x80000000/0xFFFFFFFF -> 0x80000000; REM same operands -> 0.
- DIVU 100/7, alu_gnt low for 5 cycles mid-ITER -> done in cycle 40, result 14, alu_a/alu_b constant while stalled; start pulsed mid-op -> ignored, result unchanged.
- rst asserted at ITER step 10 -> next cycle busy 0, done 0, result 0; a fresh DIVU 9/3 then completes with 3 in cycle 35.
